add_pipe_arbiter: RTL and testbench

ADD_PIPE_ARBITER -- requirements
Module: add_pipe_arbiter

---
 rtl/add_pipe_pkg.sv | 7 +
 rtl/add4_pipe.sv | 40 ++++
 rtl/add_pipe_arbiter.sv | 44 ++++
 tb/tb_add_pipe_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared widths and requester ids for the arbitrated add pipeline
package add_pipe_pkg;
  localparam int DW_DEF = 10;
  localparam int RW_DEF = DW_DEF + 2;
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/add4_pipe.sv
// add4_pipe: two-stage (a0+b0)+(a1+b1) datapath, all stages advance on enable
module add4_pipe
  import add_pipe_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          in_valid,
  input  logic          in_id,
  input  logic [4*DW-1:0] in_op,
  output logic          mid_valid,
  output logic          out_valid,
  output logic          out_id,
  output logic [DW+1:0] out_data
);
  logic [DW-1:0] a0, b0, a1, b1;
  logic [DW:0] sum0, sum1;
  logic mid_id;
  assign {a0, b0, a1, b1} = in_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum0 <= '0;
      sum1 <= '0;
      mid_valid <= 1'b0;
      mid_id <= 1'b0;
      out_valid <= 1'b0;
      out_id <= 1'b0;
      out_data <= '0;
    end else if (enable) begin
      sum0 <= {1'b0, a0} + {1'b0, b0};
      sum1 <= {1'b0, a1} + {1'b0, b1};
      mid_valid <= in_valid;
      mid_id <= in_id;
      out_valid <= mid_valid;
      out_id <= mid_id;
      out_data <= {1'b0, sum0} + {1'b0, sum1};
    end
endmodule

// File: rtl/add_pipe_arbiter.sv
// add_pipe_arbiter: round-robin arbiter between two requesters feeding add4_pipe
module add_pipe_arbiter
  import add_pipe_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [4*DW-1:0] req0_op,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4*DW-1:0] req1_op,
  output logic            req1_ready,
  output logic            res_valid,
  output logic [DW+1:0]   res_data,
  output logic            res_id,
  input  logic            res_ready,
  output logic            busy
);
  logic adv, grant1, last, mid_valid, accept;
  assign adv = !res_valid || res_ready;
  // last holds the id of the most recent accept; the other requester wins a tie
  assign grant1 = req1_valid && (!req0_valid || last == ID_REQ0);
  assign req0_ready = rst_n && adv && req0_valid && !grant1;
  assign req1_ready = rst_n && adv && grant1;
  assign accept = req0_ready || req1_ready;
  assign busy = mid_valid || res_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= ID_REQ1;
    else if (accept) last <= req1_ready ? ID_REQ1 : ID_REQ0;
  add4_pipe #(.DW(DW)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .enable(adv),
    .in_valid(accept),
    .in_id(grant1 ? ID_REQ1 : ID_REQ0),
    .in_op(grant1 ? req1_op : req0_op),
    .mid_valid(mid_valid),
    .out_valid(res_valid),
    .out_id(res_id),
    .out_data(res_data)
  );
endmodule

// File: tb/tb_add_pipe_arbiter.sv
// tb_add_pipe_arbiter: directed table of per-cycle vectors plus an async-reset sequence
module tb_add_pipe_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  logic [39:0] req0_op = '0, req1_op = '0;
  logic req0_ready, req1_ready, res_valid, res_id, busy;
  logic [11:0] res_data;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  add_pipe_arbiter #(.DW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  typedef struct {
    logic rst; logic v0; logic [39:0] op0; logic v1; logic [39:0] op1; logic rr;
    logic e_r0; logic e_r1; logic e_rv; logic [11:0] e_d; logic e_id; logic e_busy; logic chk_d;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [39:0] pk(int a0, int b0, int a1, int b1);
    return {a0[9:0], b0[9:0], a1[9:0], b1[9:0]};
  endfunction

  function automatic vec_t mk(logic rst, logic v0, logic [39:0] op0, logic v1, logic [39:0] op1, logic rr,
                              logic r0, logic r1, logic rv, int d, logic id, logic bz, logic cd);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.op0 = op0; v.v1 = v1; v.op1 = op1; v.rr = rr;
    v.e_r0 = r0; v.e_r1 = r1; v.e_rv = rv; v.e_d = d[11:0]; v.e_id = id; v.e_busy = bz; v.chk_d = cd;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  initial begin
    logic [39:0] f, a, b, z;
    f = pk(1023, 1023, 1023, 1023);
    a = pk(1, 1, 1, 1);
    b = pk(2, 2, 2, 2);
    z = '0;
    // rst v0 op0 v1 op1 rr | r0 r1 rv data id busy chk_data
    tbl.push_back(mk(0, 0, z, 0, z, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, f, 0, z, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 1, 4092, 0, 1, 1));
    tbl.push_back(mk(1, 0, z, 1, pk(1, 2, 3, 4), 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, z, 0, z, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 1, 10, 1, 1, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, a, 1, b, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, a, 1, b, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, a, 1, b, 1, 1, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 1, 0, 1, 1, 8, 1, 1, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 0, 0, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 0, 0, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 0, 0, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 1, a, 1, b, 1, 1, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 1, 8, 1, 1, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 1, 4, 0, 1, 1));
    tbl.push_back(mk(1, 0, z, 0, z, 1, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      req0_valid = tbl[i].v0; req0_op = tbl[i].op0;
      req1_valid = tbl[i].v1; req1_op = tbl[i].op1;
      res_ready = tbl[i].rr;
      #1;
      chk($sformatf("row%0d req0_ready", i), req0_ready, tbl[i].e_r0);
      chk($sformatf("row%0d req1_ready", i), req1_ready, tbl[i].e_r1);
      chk($sformatf("row%0d res_valid", i), res_valid, tbl[i].e_rv);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].chk_d) begin
        chk($sformatf("row%0d res_data", i), res_data, tbl[i].e_d);
        chk($sformatf("row%0d res_id", i), res_id, tbl[i].e_id);
      end
    end

    // two ops in flight, then an asynchronous reset pulse between clock edges
    @(negedge clk);
    req0_valid = 1'b1; req0_op = pk(5, 5, 5, 5); req1_valid = 1'b0; res_ready = 1'b1;
    #1 chk("inflight accept0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_op = pk(1, 0, 0, 0);
    #1 chk("inflight accept1", req1_ready, 1);
    @(posedge clk);
    #3;
    chk("inflight res_valid", res_valid, 1);
    chk("inflight res_data", res_data, 20);
    chk("inflight busy", busy, 1);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("async res_valid", res_valid, 0);
    chk("async busy", busy, 0);
    chk("async res_data", res_data, 0);
    chk("async res_id", res_id, 0);
    chk("async req0_ready", req0_ready, 0);
    chk("async req1_ready", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post_reset%0d res_valid", k), res_valid, 0);
      chk($sformatf("post_reset%0d busy", k), busy, 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
